// File: rtl/bin2bcd_iter.sv
// Iterative binary-to-BCD converter: a BCD weight doubles every cycle and is added into a BCD
// accumulator whenever the current operand bit is set; conversion ends once no set bits remain.
module bin2bcd_iter #(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIG    = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin_i,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [4*DIG-1:0] bcd_o,
  output logic             sign_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned BcdW = 4 * DIG;

  // True when DIG decimal digits can represent every BIN_W-bit unsigned value.
  function automatic bit digits_fit(input int unsigned bw, input int unsigned dg);
    longint unsigned maxv;
    longint unsigned pow10;
    maxv  = (64'd1 << bw) - 64'd1;
    pow10 = 64'd1;
    for (int unsigned i = 0; i < dg; i++) begin
      pow10 = pow10 * 64'd10;
      if (pow10 > maxv) return 1'b1;
    end
    return 1'b0;
  endfunction

  if (BIN_W < 2 || BIN_W > 32 || !digits_fit(BIN_W, DIG)) begin : g_param_check
    $error("bin2bcd_iter: illegal parameters BIN_W=%0d DIG=%0d", BIN_W, DIG);
  end

  // Digit-serial BCD add; the carry out of the top digit is dropped.
  function automatic logic [BcdW-1:0] bcd_add(input logic [BcdW-1:0] a,
                                               input logic [BcdW-1:0] b);
    logic [BcdW-1:0] sum;
    logic            carry;
    logic [4:0]      dsum;
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < int'(DIG); i++) begin
      dsum = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'd0, carry};
      if (dsum > 5'd9) begin
        dsum  = dsum - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i+:4] = dsum[3:0];
    end
    return sum;
  endfunction

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] sh_q, sh_d;
  logic [BcdW-1:0]  acc_q, acc_d;
  logic [BcdW-1:0]  wgt_q, wgt_d;
  logic             sign_q, sign_d;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    wgt_d   = wgt_q;
    sign_d  = sign_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StCalc;
          sign_d  = SIGNED && bin_i[BIN_W-1];
          sh_d    = sign_d ? -bin_i : bin_i;
          acc_d   = '0;
          wgt_d   = BcdW'(1);
        end
      end
      StCalc: begin
        if (sh_q[0]) acc_d = bcd_add(acc_q, wgt_q);
        wgt_d = bcd_add(wgt_q, wgt_q);
        sh_d  = sh_q >> 1;
        if (sh_d == '0) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sh_q    <= '0;
      acc_q   <= '0;
      wgt_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      wgt_q   <= wgt_d;
      sign_q  <= sign_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign bcd_o     = acc_q;
  assign sign_o    = sign_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Bench for bin2bcd_iter: three configurations driven by directed steps, with a per-instance
// scoreboard checking value, sign and latency of every result at the output handshake.
module tb_bin2bcd_iter;

  typedef struct packed {
    logic [19:0] bcd;
    logic        sign;
    int          n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          rand_en = 1'b0;

  logic [9:0]  bin0 = '0, bin1 = '0;
  logic [15:0] bin2 = '0;
  logic        iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
  logic        ordy0 = 1'b1, ordy1 = 1'b1, ordy2 = 1'b1;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, bsy0, bsy1, bsy2, sg0, sg1, sg2;
  logic [15:0] bcd0, bcd1;
  logic [19:0] bcd2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_iter #(.BIN_W(10), .DIG(4), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rst_n(rst_n), .bin_i(bin0), .in_valid(iv0), .in_ready(ir0), .bcd_o(bcd0),
    .sign_o(sg0), .out_valid(ov0), .out_ready(ordy0), .busy(bsy0)
  );

  bin2bcd_iter #(.BIN_W(10), .DIG(4), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .bin_i(bin1), .in_valid(iv1), .in_ready(ir1), .bcd_o(bcd1),
    .sign_o(sg1), .out_valid(ov1), .out_ready(ordy1), .busy(bsy1)
  );

  bin2bcd_iter #(.BIN_W(16), .DIG(5), .SIGNED(1'b0)) u_wide (
    .clk(clk), .rst_n(rst_n), .bin_i(bin2), .in_valid(iv2), .in_ready(ir2), .bcd_o(bcd2),
    .sign_o(sg2), .out_valid(ov2), .out_ready(ordy2), .busy(bsy2)
  );

  function automatic logic f_ir(input int u);
    case (u)
      0:       return ir0;
      1:       return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic f_ov(input int u);
    case (u)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic f_ordy(input int u);
    case (u)
      0:       return ordy0;
      1:       return ordy1;
      default: return ordy2;
    endcase
  endfunction

  function automatic logic f_iv(input int u);
    case (u)
      0:       return iv0;
      1:       return iv1;
      default: return iv2;
    endcase
  endfunction

  function automatic logic [19:0] f_bcd(input int u);
    case (u)
      0:       return {4'd0, bcd0};
      1:       return {4'd0, bcd1};
      default: return bcd2;
    endcase
  endfunction

  function automatic logic f_sign(input int u);
    case (u)
      0:       return sg0;
      1:       return sg1;
      default: return sg2;
    endcase
  endfunction

  function automatic int q_size(input int u);
    case (u)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_front(input int u);
    case (u)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_push(input int u, input exp_t e);
    case (u)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int u, output exp_t e);
    case (u)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Decimal reference: magnitude digits by repeated /10, latency from the highest set bit.
  function automatic exp_t model(input int u, input logic [15:0] v);
    exp_t        e;
    int unsigned mag;
    int unsigned t;
    e.sign = 1'b0;
    case (u)
      0: mag = {22'd0, v[9:0]};
      1: begin
        e.sign = v[9];
        mag    = v[9] ? 32'd1024 - {22'd0, v[9:0]} : {22'd0, v[9:0]};
      end
      default: mag = {16'd0, v};
    endcase
    e.bcd = '0;
    t = mag;
    for (int i = 0; i < 5; i++) begin
      e.bcd[4*i+:4] = 4'(t % 10);
      t = t / 10;
    end
    e.n = 1;
    for (int i = 0; i < 17; i++) if ((mag >> i) != 0) e.n = i + 1;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input int u, input logic v, input logic [15:0] d);
    case (u)
      0:       begin iv0 = v; bin0 = d[9:0]; end
      1:       begin iv1 = v; bin1 = d[9:0]; end
      default: begin iv2 = v; bin2 = d; end
    endcase
  endtask

  task automatic send(input int u, input logic [15:0] v, input bit push);
    int b = 0;
    while (f_ir(u) !== 1'b1 && b < 300) begin
      @(posedge clk); #1;
      b++;
    end
    check("send_in_ready", 32'(f_ir(u)), 32'd1);
    set_in(u, 1'b1, v);
    if (push) q_push(u, model(u, v));
    @(posedge clk); #1;
    set_in(u, 1'b0, v);
  endtask

  task automatic wait_ov(input int u);
    int b = 0;
    while (f_ov(u) !== 1'b1 && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    check("wait_out_valid", 32'(f_ov(u)), 32'd1);
  endtask

  task automatic wait_idle(input int u);
    int b = 0;
    while ((f_ir(u) !== 1'b1 || q_size(u) != 0) && b < 3000) begin
      @(posedge clk); #1;
      b++;
    end
    check("wait_idle", 32'(q_size(u)), 32'd0);
  endtask

  // Scoreboard monitor: latency on first out_valid, value/sign at the output handshake.
  initial begin
    int   start_c[3];
    bit   pend[3];
    exp_t e;
    for (int u = 0; u < 3; u++) begin
      start_c[u] = 0;
      pend[u]    = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int u = 0; u < 3; u++) pend[u] = 1'b0;
      end else begin
        for (int u = 0; u < 3; u++) begin
          if (f_iv(u) && f_ir(u)) begin
            start_c[u] = cyc + 1;
            pend[u]    = 1'b1;
          end
          if (f_ov(u)) begin
            n_cmp++;
            assert (q_size(u) != 0) else begin
              n_fail++;
              $error("FAIL orphan_out%0d: observed out_valid with queue size 0 expected >0", u);
            end
            if (q_size(u) != 0) begin
              e = q_front(u);
              if (pend[u]) begin
                check($sformatf("latency%0d", u), 32'(cyc - start_c[u]), 32'(e.n));
                pend[u] = 1'b0;
              end
              if (f_ordy(u)) begin
                q_pop(u, e);
                check($sformatf("bcd%0d", u), 32'(f_bcd(u)), 32'(e.bcd));
                check($sformatf("sign%0d", u), 32'(f_sign(u)), 32'(e.sign));
              end
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      ordy2 = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ir0), 32'd1);
    check("rst_out_valid", 32'(ov0), 32'd0);
    check("rst_busy", 32'(bsy0), 32'd0);
    check("rst_bcd", 32'(bcd0), 32'd0);
    check("rst_sign", 32'(sg1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-width operand; in_valid pulses while busy must be ignored.
    send(0, 16'd1023, 1'b1);
    iv0 = 1'b1; bin0 = 10'd77;
    repeat (3) begin @(posedge clk); #1; end
    iv0 = 1'b0;
    check("busy_during_calc", 32'(bsy0), 32'd1);
    wait_idle(0);
    send(0, 16'd0, 1'b1);
    wait_idle(0);
    send(0, 16'd5, 1'b1);
    wait_idle(0);

    // Consumer stall: result and in_ready must hold.
    ordy0 = 1'b0;
    send(0, 16'd999, 1'b1);
    wait_ov(0);
    repeat (7) begin
      check("stall_bcd", 32'(bcd0), 32'h0999);
      check("stall_in_ready", 32'(ir0), 32'd0);
      check("stall_out_valid", 32'(ov0), 32'd1);
      @(posedge clk); #1;
    end
    ordy0 = 1'b1;
    @(posedge clk); #1;
    check("idle_after_handshake", 32'(ir0), 32'd1);

    // Output handshake coinciding with a new in_valid: operand taken one cycle later.
    ordy0 = 1'b0;
    send(0, 16'd33, 1'b1);
    wait_ov(0);
    ordy0 = 1'b1; iv0 = 1'b1; bin0 = 10'd44;
    q_push(0, model(0, 16'd44));
    @(posedge clk); #1;
    check("no_accept_on_out_hs", 32'(bsy0), 32'd0);
    @(posedge clk); #1;
    iv0 = 1'b0;
    check("accept_next_cycle", 32'(bsy0), 32'd1);
    wait_idle(0);

    // Signed operands including the most negative value.
    send(1, 16'h0200, 1'b1);
    wait_idle(1);
    send(1, 16'h03FF, 1'b1);
    wait_idle(1);
    send(1, 16'd300, 1'b1);
    wait_idle(1);

    // Reset in the 4th CALC cycle drops the conversion.
    send(0, 16'd700, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("pre_reset_busy", 32'(bsy0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(ir0), 32'd1);
    check("mid_rst_out_valid", 32'(ov0), 32'd0);
    check("mid_rst_busy", 32'(bsy0), 32'd0);
    check("mid_rst_bcd", 32'(bcd0), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("post_rst_out_valid", 32'(ov0), 32'd0);
    send(0, 16'd42, 1'b1);
    wait_idle(0);

    // Random sweep on the wide instance with a randomly stalling consumer.
    rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      v = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      if (i == 0) v = 16'hFFFF;
      if (i == 1) v = 16'd0;
      send(2, v, 1'b1);
    end
    wait_idle(2);
    rand_en = 1'b0;

    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);
    check("q2_empty", 32'(q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
